// File: rtl/copiador_mem512_if.sv
// Memory bus between the block-move engine and the 512x16 memory.
// Read data is combinational from posicao; writes land on the rising edge.
interface copiador_mem512_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] posicao;
  logic              enable_write;
  logic [DATA_W-1:0] valor_entrada;
  logic [DATA_W-1:0] valor_saida;

  modport master (
    output posicao,
    output enable_write,
    output valor_entrada,
    input  valor_saida
  );

  modport slave (
    input  posicao,
    input  enable_write,
    input  valor_entrada,
    output valor_saida
  );
endinterface

// File: rtl/copiador_mem512.sv
// Block-move engine: copies N words (read, then write) from origem to destino
// in ascending order, accumulating a mod-2^16 checksum of the copied words.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OCIOSO   | idle, waiting for iniciar; captures addresses and count
// LER      | drive ptr_src, latch the read word and add it to soma
// ESCREVER | drive ptr_dst with write enable, advance pointers, count down
// FIM      | one-cycle concluido pulse, then back to OCIOSO
module copiador_mem512 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              sinal_clock,
  input  logic              sinal_reset_n,
  input  logic              iniciar,
  input  logic [ADDR_W-1:0] origem,
  input  logic [ADDR_W-1:0] destino,
  input  logic [ADDR_W:0]   quantidade,
  output logic              ocupado,
  output logic              concluido,
  output logic [DATA_W-1:0] soma,
  copiador_mem512_if.master mem
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LER      = 2'd1,
    ESCREVER = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [ADDR_W:0] QTD_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] QTD_UM  = {{ADDR_W{1'b0}}, 1'b1};

  estado_t           estado, estado_prox;
  logic [ADDR_W-1:0] ptr_src, ptr_dst;
  logic [ADDR_W:0]   restante;
  logic [ADDR_W:0]   qtd_lim;
  logic [DATA_W-1:0] dado_reg;

  assign qtd_lim = (quantidade > QTD_MAX) ? QTD_MAX : quantidade;

  always_ff @(posedge sinal_clock or negedge sinal_reset_n) begin
    if (!sinal_reset_n) begin
      estado   <= OCIOSO;
      ptr_src  <= '0;
      ptr_dst  <= '0;
      restante <= '0;
      dado_reg <= '0;
      soma     <= '0;
    end else begin
      estado <= estado_prox;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            ptr_src  <= origem;
            ptr_dst  <= destino;
            restante <= qtd_lim;
            soma     <= '0;
          end
        end
        LER: begin
          dado_reg <= mem.valor_saida;
          soma     <= soma + mem.valor_saida;
        end
        ESCREVER: begin
          // Pointers are ADDR_W wide, so 511+1 wraps to 0 naturally.
          ptr_src  <= ptr_src + ADDR_W'(1);
          ptr_dst  <= ptr_dst + ADDR_W'(1);
          restante <= restante - QTD_UM;
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs depend only on state and registers, never on iniciar.
  always_comb begin
    estado_prox      = estado;
    ocupado          = 1'b0;
    concluido        = 1'b0;
    mem.posicao      = '0;
    mem.enable_write = 1'b0;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          estado_prox = (qtd_lim == '0) ? FIM : LER;
        end
      end
      LER: begin
        ocupado     = 1'b1;
        mem.posicao = ptr_src;
        estado_prox = ESCREVER;
      end
      ESCREVER: begin
        ocupado          = 1'b1;
        mem.posicao      = ptr_dst;
        mem.enable_write = 1'b1;
        estado_prox      = (restante == QTD_UM) ? FIM : LER;
      end
      FIM: begin
        ocupado     = 1'b1;
        concluido   = 1'b1;
        estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  assign mem.valor_entrada = dado_reg;

endmodule
